pipe_skid_reg: RTL

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline stage: main register plus one skid register, with stall/flush control.
// Optional perf counters are built only when PIPE_SKID_PERF_EN is defined.
module pipe_skid_reg #(
  parameter int unsigned          WIDTH   = 128,
  parameter logic [WIDTH-1:0]     NOP_VAL = '0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [31:0]      stall_cnt,
  output logic [15:0]      flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_xfer, out_xfer;

  assign in_ready  = en & ~flush & (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = out_valid ? main_q : NOP_VAL;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready & en;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (en) begin
      if (flush) begin
        // Flush discards everything, including a same-cycle offer from upstream.
        state_d = EMPTY;
        main_d  = NOP_VAL;
        skid_d  = NOP_VAL;
      end else begin
        unique case (state_q)
          EMPTY: begin
            if (in_xfer) begin
              state_d = ONE;
              main_d  = in_data;
            end
          end
          ONE: begin
            if (in_xfer && out_xfer) begin
              main_d = in_data;
            end else if (in_xfer) begin
              state_d = FULL;
              skid_d  = in_data;
            end else if (out_xfer) begin
              state_d = EMPTY;
            end
          end
          FULL: begin
            if (out_xfer) begin
              state_d = ONE;
              main_d  = skid_q;
            end
          end
          default: state_d = EMPTY;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= EMPTY;
      main_q  <= NOP_VAL;
      skid_q  <= NOP_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_SKID_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (en && out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (en && flush && (state_q != EMPTY) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 16'd0;
`endif

endmodule
